reg_delay_rx_buf: RTL

- Receive-end buffer for a fixed-latency, non-stallable register delay pipeline, such as the TPU operand/result delay chains.
- Issues credits to the upstream launcher so it only injects data the buffer is guaranteed to absorb.
- Captures words as they emerge PIPE_LAT cycles later and presents them to a valid/ready consumer.
- Flags protocol violations: overflow and spurious arrivals.

---
 rtl/reg_delay_rx_buf_pkg.sv | 17 +
 rtl/reg_delay_rx_buf_mem.sv | 49 ++++
 rtl/reg_delay_rx_buf.sv | 108 ++++++++++
 3 files changed

// File: rtl/reg_delay_rx_buf_pkg.sv
// Shared constants and width helpers for the register-delay receive buffer.
// Imported by the buffer top and its storage sub-module.
package reg_delay_rx_buf_pkg;

   // Latency of the 3-stage operand/result delay chains feeding this buffer.
   localparam int unsigned PIPE_LAT_3L = 3;

   // Width of a counter that must hold every value from 0 to depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit is_pow2(input int unsigned value);
      return (value != 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/reg_delay_rx_buf_mem.sv
// DEPTH x DATA_WIDTH register array for the receive buffer, with wrapping
// write/read pointers and a show-ahead asynchronous read port.
module rx_fifo_mem
   import reg_delay_rx_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 18,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;

   // NOTE: every comb output gets a default before any branch, so no path leaves it unassigned (no latch).
   // NOTE: comb logic uses blocking '=', clocked state uses non-blocking '<=' only.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; contents are only meaningful behind level != 0.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/reg_delay_rx_buf.sv
// Receive-end buffer for a fixed-latency register delay pipeline: credits the
// launcher, captures arriving words, serves a valid/ready consumer, flags misuse.
module reg_delay_rx_buf
   import reg_delay_rx_buf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 18,
   parameter int unsigned PIPE_LAT   = PIPE_LAT_3L,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          issue_req,
   output logic                          issue_ok,
   input  logic                          pipe_valid,
   input  logic [DATA_WIDTH-1:0]         pipe_data,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   input  logic                          out_ready,
   output logic [cnt_width(DEPTH)-1:0]   credit_cnt,
   output logic [cnt_width(DEPTH)-1:0]   level,
   output logic                          overflow_err,
   output logic                          spurious_err
);

   localparam int unsigned      CNT_W   = cnt_width(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   if (!is_pow2(DEPTH) || (DEPTH < PIPE_LAT)) begin : g_bad_cfg
      $error("reg_delay_rx_buf: DEPTH must be a power of two and >= PIPE_LAT");
   end

   logic [CNT_W-1:0] credit_q, credit_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] in_flight_q, in_flight_d;
   logic             overflow_q, overflow_d;
   logic             spurious_q, spurious_d;

   logic accept, pop, full, push_en;

   assign issue_ok  = (credit_q != '0);
   assign out_valid = (level_q != '0);
   assign full      = (level_q == DEPTH_C);
   assign accept    = issue_req && issue_ok;
   assign pop       = out_valid && out_ready;
   // A full buffer still takes a word when the same cycle frees a slot.
   assign push_en   = pipe_valid && (!full || pop);

   always_comb begin
      credit_d    = credit_q;
      level_d     = level_q;
      in_flight_d = in_flight_q;
      overflow_d  = overflow_q | (pipe_valid && full && !pop);
      spurious_d  = spurious_q | (pipe_valid && !accept && (in_flight_q == '0));

      unique case ({accept, pop})
         2'b10:   credit_d = credit_q - CNT_W'(1);
         2'b01:   credit_d = credit_q + CNT_W'(1);
         default: credit_d = credit_q;
      endcase

      unique case ({push_en, pop})
         2'b10:   level_d = level_q + CNT_W'(1);
         2'b01:   level_d = level_q - CNT_W'(1);
         default: level_d = level_q;
      endcase

      // A stray arrival with nothing outstanding leaves the count pinned at zero.
      if (accept && !pipe_valid) begin
         in_flight_d = in_flight_q + CNT_W'(1);
      end else if (!accept && pipe_valid && (in_flight_q != '0)) begin
         in_flight_d = in_flight_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q    <= DEPTH_C;
         level_q     <= '0;
         in_flight_q <= '0;
         overflow_q  <= 1'b0;
         spurious_q  <= 1'b0;
      end else begin
         credit_q    <= credit_d;
         level_q     <= level_d;
         in_flight_q <= in_flight_d;
         overflow_q  <= overflow_d;
         spurious_q  <= spurious_d;
      end
   end

   rx_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_en),
      .pop     (pop),
      .wr_data (pipe_data),
      .rd_data (out_data)
   );

   assign credit_cnt   = credit_q;
   assign level        = level_q;
   assign overflow_err = overflow_q;
   assign spurious_err = spurious_q;

endmodule
